// File: rtl/instr_cache_refill.sv
// Instruction cache miss/refill controller: stalls fetch on a miss, reads one line as
// BEATS memory beats, then writes the assembled line into the cache core.
module instr_cache_refill #(
  parameter int unsigned asize = 32,
  parameter int unsigned dsize = 32,
  parameter int unsigned bbits = 5,
  parameter int unsigned bsize = 8 << bbits,
  parameter int unsigned BEATS = bsize / dsize
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             SYS,
  input  logic             fetch_req,
  input  logic [asize-1:0] fetch_addr,
  input  logic             hit,
  output logic [asize-1:0] cache_addr,
  output logic             bwrite,
  output logic [bsize-1:0] block_out,
  output logic             stall,
  output logic             mem_rd,
  output logic [asize-1:0] mem_addr,
  input  logic [dsize-1:0] mem_rdata,
  input  logic             mem_rvalid,
  output logic             err
);

  localparam int unsigned CntW = $clog2(BEATS);
  localparam logic [CntW-1:0] LastBeat = CntW'(BEATS - 1);

  typedef enum logic [2:0] {StIdle, StReq, StFill, StWrite, StDone, StDrain} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [bsize-1:0] buf_q, buf_d;
  logic [asize-1:0] line_q, line_d;
  logic             err_q, err_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    line_d  = line_q;
    // Beats are only legal while filling or draining a line.
    err_d   = err_q | (mem_rvalid & (state_q inside {StIdle, StReq, StWrite, StDone}));
    unique case (state_q)
      StIdle: begin
        if (!SYS && fetch_req && !hit) begin
          line_d  = {fetch_addr[asize-1:bbits], {bbits{1'b0}}};
          state_d = StReq;
        end
      end
      StReq: begin
        cnt_d   = '0;
        state_d = SYS ? StDrain : StFill;
      end
      StFill: begin
        if (mem_rvalid) begin
          cnt_d = cnt_q + 1'b1;
          if (!SYS) begin
            // Beat 0 is the lowest address and lands in the MSBs.
            for (int i = 0; i < int'(BEATS); i++) begin
              if (cnt_q == CntW'(i)) buf_d[bsize-1-dsize*i -: dsize] = mem_rdata;
            end
          end
          if (cnt_q == LastBeat) state_d = SYS ? StIdle : StWrite;
          else if (SYS)          state_d = StDrain;
        end else if (SYS) begin
          state_d = StDrain;
        end
      end
      StWrite: state_d = SYS ? StIdle : StDone;
      StDone:  state_d = StIdle;
      StDrain: begin
        if (mem_rvalid) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LastBeat) state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      buf_q   <= '0;
      line_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      line_q  <= line_d;
      err_q   <= err_d;
    end
  end

  assign stall      = RESET & ((state_q != StIdle) | (fetch_req & ~hit));
  assign mem_rd     = RESET & (state_q == StReq);
  assign bwrite     = RESET & ~SYS & (state_q == StWrite);
  assign cache_addr = (state_q == StIdle) ? fetch_addr : line_q;
  assign mem_addr   = line_q;
  assign block_out  = buf_q;
  assign err        = err_q;

endmodule

// File: tb/tb_instr_cache_refill.sv
// Randomized bench for instr_cache_refill: drives refills beat by beat and checks
// strobes, stall, addresses and assembled lines against expectations built here.
module tb_instr_cache_refill;

  logic         CLK = 1'b0;
  logic         RESET, SYS, fetch_req, hit, mem_rvalid;
  logic [31:0]  fetch_addr, mem_rdata, cache_addr, mem_addr;
  logic         bwrite, stall, mem_rd, err;
  logic [255:0] block_out;

  logic         nxt_rst, nxt_req, nxt_hit;
  logic [31:0]  nxt_addr;
  int           total = 0;
  int           bad = 0;

  instr_cache_refill dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .SYS        (SYS),
    .fetch_req  (fetch_req),
    .fetch_addr (fetch_addr),
    .hit        (hit),
    .cache_addr (cache_addr),
    .bwrite     (bwrite),
    .block_out  (block_out),
    .stall      (stall),
    .mem_rd     (mem_rd),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .mem_rvalid (mem_rvalid),
    .err        (err)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: apply inputs at the falling edge, check outputs before the rising edge.
  task automatic cyc(input logic rv, input logic [31:0] d, input logic sys,
                     input logic es, input logic erd, input logic ebw);
    @(negedge CLK);
    RESET      = nxt_rst;
    fetch_req  = nxt_req;
    hit        = nxt_hit;
    fetch_addr = nxt_addr;
    mem_rvalid = rv;
    mem_rdata  = d;
    SYS        = sys;
    #1;
    check_eq("stall", stall, es);
    check_eq("mem_rd", mem_rd, erd);
    check_eq("bwrite", bwrite, ebw);
  endtask

  task automatic do_reset();
    nxt_rst = 1'b0;
    nxt_req = 1'b0;
    nxt_hit = 1'b0;
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    nxt_rst = 1'b1;
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("rst_err", err, 1'b0);
    check_eq("rst_buf", block_out, 256'h0);
  endtask

  // mode: 0 normal, 1 SYS after k beats, 2 SYS on final beat, 3 SYS in write cycle,
  //       4 RESET after k beats, 5 SYS during the request cycle
  task automatic refill(input logic [31:0] addr, input bit fixed, input int gmin, input int gmax,
                        input int mode, input int k);
    logic [31:0]  beats [8];
    logic [31:0]  line;
    logic [255:0] exp_line;
    bit           aborted;
    line     = {addr[31:5], 5'b0};
    exp_line = '0;
    for (int i = 0; i < 8; i++) begin
      beats[i] = fixed ? 32'h1111_1111 * (i + 1) : $urandom;
      exp_line = (exp_line << 32) | {224'h0, beats[i]};
    end
    aborted  = (mode == 5);
    nxt_req  = 1'b1;
    nxt_hit  = 1'b0;
    nxt_addr = addr;
    cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    check_eq("miss_cache_addr", cache_addr, addr);
    cyc(1'b0, 32'h0, aborted, 1'b1, 1'b1, 1'b0);
    check_eq("mem_addr", mem_addr, line);
    check_eq("req_cache_addr", cache_addr, line);
    for (int i = 0; i < 8; i++) begin
      int g;
      if (mode == 1 && i == k) begin
        cyc(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);
        aborted = 1'b1;
      end
      if (mode == 4 && i == k) begin
        nxt_rst = 1'b0;
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        nxt_rst = 1'b1;
        nxt_req = 1'b0;
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'hdead_beef, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("idle_beat_err", err, 1'b1);
        do_reset();
        return;
      end
      g = gmin + int'($urandom_range(gmax - gmin, 0));
      for (int j = 0; j < g; j++) begin
        nxt_addr = $urandom;
        cyc(1'b0, 32'h0, aborted ? 1'($urandom_range(1, 0)) : 1'b0, 1'b1, 1'b0, 1'b0);
        check_eq("hold_mem_addr", mem_addr, line);
      end
      cyc(1'b1, beats[i], (mode == 2 && i == 7) ? 1'b1 :
          (aborted ? 1'($urandom_range(1, 0)) : 1'b0), 1'b1, 1'b0, 1'b0);
    end
    nxt_addr = addr;
    if (aborted || mode == 2) begin
      nxt_req = 1'b0;
      cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      check_eq("abort_err", err, 1'b0);
      return;
    end
    if (mode == 3) begin
      cyc(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);
      nxt_req = 1'b0;
      cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      return;
    end
    cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1);
    check_eq("block_out", block_out, exp_line);
    check_eq("wr_cache_addr", cache_addr, line);
    nxt_hit = 1'b1;
    cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("hit_cache_addr", cache_addr, addr);
    check_eq("refill_err", err, 1'b0);
  endtask

  initial begin
    nxt_addr = 32'h0;
    do_reset();
    check_eq("rst_cache_addr", cache_addr, 32'h0);

    // Hits never stall or touch memory.
    for (int i = 0; i < 6; i++) begin
      nxt_req  = 1'b1;
      nxt_hit  = 1'b1;
      nxt_addr = $urandom;
      cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      check_eq("hit_addr", cache_addr, nxt_addr);
    end

    refill(32'h0000_1044, 1'b1, 0, 0, 0, 0);
    refill(32'h0000_1044, 1'b1, 2, 2, 0, 0);
    refill($urandom, 1'b0, 0, 2, 1, 3);
    refill(32'h0000_1044, 1'b1, 0, 0, 0, 0);
    refill($urandom, 1'b0, 0, 1, 4, 4);
    refill(32'h0000_0040, 1'b0, 0, 0, 0, 0);
    refill(32'h0000_2040, 1'b0, 0, 0, 0, 0);
    refill($urandom, 1'b0, 0, 2, 2, 0);
    refill($urandom, 1'b0, 0, 2, 3, 0);
    refill($urandom, 1'b0, 0, 2, 5, 0);
    refill($urandom, 1'b0, 0, 0, 0, 0);

    for (int n = 0; n < 30; n++) begin
      int m;
      m = int'($urandom_range(5, 0));
      refill($urandom, 1'b0, 0, int'($urandom_range(3, 0)), m, int'($urandom_range(7, 1)));
      if (m != 0) refill($urandom, 1'b0, 0, 1, 0, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
